writeback_rf: RTL and testbench
===============================

WRITEBACK_RF -- requirements
Module: writeback_rf

Interface
REQ-001 SHALL have parameter IALU_WORD_WIDTH, default 16, meaning result/register word width.
REQ-002 SHALL have parameter REG_IDX_WIDTH, default 4, meaning register index width; register count NUM_REGS = 2**REG_IDX_WIDTH.
REQ-003 SHALL have parameter R0_HARDWIRED, default 1, meaning register 0 reads zero and ignores writes when 1.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_act_write_res_to_reg, input, 1, the incoming instruction writes a register.
REQ-007 SHALL have port in_res, input, IALU_WORD_WIDTH, the ALU result.
REQ-008 SHALL have port in_res_reg_idx, input, REG_IDX_WIDTH, the destination register.
REQ-009 SHALL have port in_res_src, input, 1, where 0 = ALU result and 1 = memory load data.
REQ-010 SHALL have port in_mem_data, input, IALU_WORD_WIDTH, the load data.
REQ-011 SHALL have port in_mem_byte, input, 1, byte load: low 8 bits sign-extended.
REQ-012 SHALL have port in_stall, input, 1, freezing the stage.
REQ-013 SHALL have ports in_rd_idx_a and in_rd_idx_b, input, REG_IDX_WIDTH, the decode read indices.
REQ-014 SHALL have ports out_rd_data_a and out_rd_data_b, output, IALU_WORD_WIDTH, the read data.
REQ-015 SHALL have port out_fwd_valid, output, 1, a pending write is in the stage.
REQ-016 SHALL have port out_fwd_idx, output, REG_IDX_WIDTH, the pending destination.
REQ-017 SHALL have port out_fwd_data, output, IALU_WORD_WIDTH, the pending write data for execute forwarding.

Function
REQ-018 SHALL sample act, res, reg_idx, res_src, mem_data and mem_byte into stage registers on every edge where in_stall=0 and reset=0.
REQ-019 SHALL hold all stage registers unchanged on edges where in_stall=1.
REQ-020 SHALL form write data combinationally from stage registers: src=0 -> res; src=1, byte=0 -> mem_data; src=1, byte=1 -> sign-extend mem_data[7:0].
REQ-021 SHALL write the write data into RF[idx] on the edge ending the stage cycle when act=1 and in_stall=0, giving latency 2 edges from input to RF update.
REQ-022 SHALL suppress the RF write during in_stall=1; the write is retried once stall drops, and is never duplicated or lost.
REQ-023 SHALL suppress writes to index 0 when R0_HARDWIRED=1, with out_fwd_valid=0 for such an instruction.
REQ-024 SHALL make read ports combinational: return the write data if stage act=1 and idx matches (bypass), else RF[idx]; index 0 returns 0 when R0_HARDWIRED=1.
REQ-025 SHALL keep bypass active during stall, so a stalled pending write remains visible on the read ports.
REQ-026 SHALL drive out_fwd_valid = stage act (subject to REQ-023), with out_fwd_idx/out_fwd_data = stage idx/write data.
REQ-027 SHALL serve both read ports independently; equal indices both return the same value.

Reset
REQ-028 SHALL, when reset=1 at an edge, clear all stage registers to 0 and all NUM_REGS RF entries to 0, regardless of in_stall.
REQ-029 SHALL drive outputs after reset as follows: out_fwd_valid=0, out_fwd_idx=0, out_fwd_data=0, and read data 0 for every index.
REQ-030 SHALL drop a write pending when reset is asserted mid-operation; it never reaches the RF.

Structure
REQ-031 SHALL place the word/index width defaults and the res_src encoding constants (SRC_ALU=0, SRC_MEM=1) in the shared swt16 package.
REQ-032 SHALL use one sub-module, regfile_2r1w (NUM_REGS entries, 2 combinational reads, 1 synchronous write, synchronous clear); stage registers, data select and bypass stay in writeback_rf.

Verification
REQ-033 SHALL cover a basic write: act=1, src=0, res=0x1234, idx=3 -> after 2 edges rd_idx_a=3 reads 0x1234; out_fwd_valid=1 for 1 cycle.
REQ-034 SHALL cover bypass: the same write with rd_idx_b=3 in the stage cycle -> out_rd_data_b=0x1234 before the RF update.
REQ-035 SHALL cover a byte load: src=1, byte=1, mem_data=0x00F0, idx=5 -> RF[5]=0xFFF0; with byte=0 -> 0x00F0.
REQ-036 SHALL cover stall: write 0xBEEF to idx 7 then in_stall=1 for 3 cycles -> RF[7] unchanged while reads return 0xBEEF via bypass; after release RF[7]=0xBEEF, written once.
REQ-037 SHALL cover R0: act=1, idx=0, res=0xFFFF -> read of idx 0 = 0 and out_fwd_valid=0.
REQ-038 SHALL cover reset mid-operation: a write pending in the stage plus reset=1 -> out_fwd_valid=0, target register reads 0, and all registers read 0.

Source files
------------

// File: rtl/swt16_pkg.sv
// Shared widths and encodings for the swt16 integer pipeline.
package swt16_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned IDX_WIDTH  = 4;

  // Encoding of the result-source select carried with each instruction.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/regfile_2r1w.sv
// Register array: two combinational read ports, one synchronous write port,
// synchronous clear of every entry.
module regfile_2r1w #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_a_i,
  input  logic [IDX_W-1:0]  rd_idx_b_i,
  output logic [WORD_W-1:0] rd_data_a_o,
  output logic [WORD_W-1:0] rd_data_b_o
);

  localparam int unsigned NUM_REGS = 2 ** IDX_W;

  logic [WORD_W-1:0] mem_q [NUM_REGS];

  // Clear all entries on reset, otherwise apply the single write.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_a_o = mem_q[rd_idx_a_i];
  assign rd_data_b_o = mem_q[rd_idx_b_i];

endmodule

// File: rtl/writeback_rf.sv
// Writeback stage with register file: stage registers, load-data select,
// register-file write and read-port bypass of the pending write.
module writeback_rf
  import swt16_pkg::*;
#(
  parameter int unsigned IALU_WORD_WIDTH = WORD_WIDTH,
  parameter int unsigned REG_IDX_WIDTH   = IDX_WIDTH,
  parameter bit          R0_HARDWIRED    = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_write_res_to_reg,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_res_src,
  input  logic [IALU_WORD_WIDTH-1:0] in_mem_data,
  input  logic                       in_mem_byte,
  input  logic                       in_stall,
  input  logic [REG_IDX_WIDTH-1:0]   in_rd_idx_a,
  input  logic [REG_IDX_WIDTH-1:0]   in_rd_idx_b,
  output logic [IALU_WORD_WIDTH-1:0] out_rd_data_a,
  output logic [IALU_WORD_WIDTH-1:0] out_rd_data_b,
  output logic                       out_fwd_valid,
  output logic [REG_IDX_WIDTH-1:0]   out_fwd_idx,
  output logic [IALU_WORD_WIDTH-1:0] out_fwd_data
);

  typedef struct packed {
    logic                       act;
    logic [IALU_WORD_WIDTH-1:0] res;
    logic [REG_IDX_WIDTH-1:0]   idx;
    logic                       src;
    logic [IALU_WORD_WIDTH-1:0] mem_data;
    logic                       mem_byte;
  } stage_t;

  stage_t                       stage_d, stage_q;
  logic [IALU_WORD_WIDTH-1:0]   wr_data_c;
  logic                         r0_dest_c;
  logic                         wr_act_c;
  logic                         rf_we_c;
  logic [IALU_WORD_WIDTH-1:0]   rf_rd_a_c, rf_rd_b_c;

  // Stage load: capture the incoming instruction unless the stage is frozen.
  always_comb begin
    stage_d = stage_q;
    if (!in_stall) begin
      stage_d.act      = in_act_write_res_to_reg;
      stage_d.res      = in_res;
      stage_d.idx      = in_res_reg_idx;
      stage_d.src      = in_res_src;
      stage_d.mem_data = in_mem_data;
      stage_d.mem_byte = in_mem_byte;
    end
  end

  // Stage register; reset wins over stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Write data select: ALU result, full load word or sign-extended byte.
  always_comb begin
    wr_data_c = stage_q.res;
    if (stage_q.src == SRC_MEM) begin
      if (stage_q.mem_byte) begin
        wr_data_c = IALU_WORD_WIDTH'($signed(stage_q.mem_data[7:0]));
      end else begin
        wr_data_c = stage_q.mem_data;
      end
    end
  end

  // A write aimed at a hardwired r0 is treated as no write at all.
  assign r0_dest_c = R0_HARDWIRED && (stage_q.idx == '0);
  assign wr_act_c  = stage_q.act && !r0_dest_c;
  assign rf_we_c   = wr_act_c && !in_stall && !reset;

  regfile_2r1w #(
    .WORD_W (IALU_WORD_WIDTH),
    .IDX_W  (REG_IDX_WIDTH)
  ) u_rf (
    .clock_i     (clock),
    .reset_i     (reset),
    .we_i        (rf_we_c),
    .wr_idx_i    (stage_q.idx),
    .wr_data_i   (wr_data_c),
    .rd_idx_a_i  (in_rd_idx_a),
    .rd_idx_b_i  (in_rd_idx_b),
    .rd_data_a_o (rf_rd_a_c),
    .rd_data_b_o (rf_rd_b_c)
  );

  // Read ports: pending write bypasses the array, r0 forced to zero.
  always_comb begin
    out_rd_data_a = rf_rd_a_c;
    out_rd_data_b = rf_rd_b_c;
    if (wr_act_c && (in_rd_idx_a == stage_q.idx)) out_rd_data_a = wr_data_c;
    if (wr_act_c && (in_rd_idx_b == stage_q.idx)) out_rd_data_b = wr_data_c;
    if (R0_HARDWIRED && (in_rd_idx_a == '0)) out_rd_data_a = '0;
    if (R0_HARDWIRED && (in_rd_idx_b == '0)) out_rd_data_b = '0;
  end

  assign out_fwd_valid = wr_act_c;
  assign out_fwd_idx   = stage_q.idx;
  assign out_fwd_data  = wr_data_c;

endmodule

// File: tb/tb_writeback_rf.sv
// Self-checking bench for writeback_rf: directed scenarios plus a random
// write/stall stream checked through a commit scoreboard.
module tb_writeback_rf;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_act_write_res_to_reg;
  logic [15:0] in_res;
  logic [3:0]  in_res_reg_idx;
  logic        in_res_src;
  logic [15:0] in_mem_data;
  logic        in_mem_byte;
  logic        in_stall;
  logic [3:0]  in_rd_idx_a;
  logic [3:0]  in_rd_idx_b;
  logic [15:0] out_rd_data_a;
  logic [15:0] out_rd_data_b;
  logic        out_fwd_valid;
  logic [3:0]  out_fwd_idx;
  logic [15:0] out_fwd_data;

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_rf [16];
  int          checks = 0;
  int          errors = 0;

  writeback_rf dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_act_write_res_to_reg (in_act_write_res_to_reg),
    .in_res                  (in_res),
    .in_res_reg_idx          (in_res_reg_idx),
    .in_res_src              (in_res_src),
    .in_mem_data             (in_mem_data),
    .in_mem_byte             (in_mem_byte),
    .in_stall                (in_stall),
    .in_rd_idx_a             (in_rd_idx_a),
    .in_rd_idx_b             (in_rd_idx_b),
    .out_rd_data_a           (out_rd_data_a),
    .out_rd_data_b           (out_rd_data_b),
    .out_fwd_valid           (out_fwd_valid),
    .out_fwd_idx             (out_fwd_idx),
    .out_fwd_data            (out_fwd_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_wdata(input logic src, input logic mb,
                                            input logic [15:0] res, input logic [15:0] mem);
    if (!src) return res;
    if (mb)   return {{8{mem[7]}}, mem[7:0]};
    return mem;
  endfunction

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive_wr(input logic act, input logic [3:0] idx, input logic src,
                          input logic mb, input logic [15:0] res, input logic [15:0] mem);
    exp_t e;
    in_act_write_res_to_reg = act;
    in_res_reg_idx          = idx;
    in_res_src              = src;
    in_mem_byte             = mb;
    in_res                  = res;
    in_mem_data             = mem;
    if (act && idx != 4'd0) begin
      e.idx  = idx;
      e.data = exp_wdata(src, mb, res, mem);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    in_act_write_res_to_reg = 1'b0;
    in_res = 16'h0; in_res_reg_idx = 4'h0; in_res_src = 1'b0;
    in_mem_data = 16'h0; in_mem_byte = 1'b0;
  endtask

  task automatic read_a(input logic [3:0] idx, input string tag, input logic [15:0] exp);
    in_rd_idx_a = idx;
    #1;
    chk(tag, out_rd_data_a, exp);
  endtask

  // Commit monitor: a write leaves the stage when it is valid and not stalled.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_fwd_valid && !in_stall) begin
      if (exp_q.size() == 0) begin
        chk("fwd_unexpected", {12'h0, out_fwd_idx}, 16'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("fwd_idx", {12'h0, out_fwd_idx}, {12'h0, e.idx});
        chk("fwd_data", out_fwd_data, e.data);
        model_rf[e.idx] = e.data;
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) model_rf[i] = 16'h0;
    reset = 1'b1; in_stall = 1'b0; in_rd_idx_a = 4'h0; in_rd_idx_b = 4'h0;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_fwd_valid", {15'h0, out_fwd_valid}, 16'h0);
    chk("rst_fwd_idx", {12'h0, out_fwd_idx}, 16'h0);
    chk("rst_fwd_data", out_fwd_data, 16'h0);
    for (int i = 0; i < 16; i++) read_a(4'(i), "rst_read", 16'h0);

    // Basic ALU write with bypass on port b during the stage cycle.
    drive_wr(1'b1, 4'd3, 1'b0, 1'b0, 16'h1234, 16'hDEAD);
    in_rd_idx_b = 4'd3;
    tick();
    idle();
    #1;
    chk("basic_fwd_valid", {15'h0, out_fwd_valid}, 16'h1);
    chk("bypass_b", out_rd_data_b, 16'h1234);
    chk("basic_rf_pre", dut.u_rf.mem_q[3], 16'h0);
    tick();
    chk("basic_fwd_drop", {15'h0, out_fwd_valid}, 16'h0);
    read_a(4'd3, "basic_read", 16'h1234);

    // Byte load sign-extends, word load does not.
    drive_wr(1'b1, 4'd5, 1'b1, 1'b1, 16'hAAAA, 16'h00F0);
    tick(); idle(); tick();
    read_a(4'd5, "byte_load", 16'hFFF0);
    drive_wr(1'b1, 4'd5, 1'b1, 1'b0, 16'hAAAA, 16'h00F0);
    tick(); idle(); tick();
    read_a(4'd5, "word_load", 16'h00F0);

    // Stall holds a pending write; bypass keeps it visible.
    drive_wr(1'b1, 4'd7, 1'b0, 1'b0, 16'hBEEF, 16'h0);
    tick();
    idle();
    in_stall = 1'b1;
    in_rd_idx_b = 4'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      read_a(4'd7, "stall_bypass_a", 16'hBEEF);
      chk("stall_bypass_b", out_rd_data_b, 16'hBEEF);
      chk("stall_fwd_valid", {15'h0, out_fwd_valid}, 16'h1);
      chk("stall_rf_hold", dut.u_rf.mem_q[7], 16'h0);
    end
    in_stall = 1'b0;
    tick();
    chk("stall_rf_after", dut.u_rf.mem_q[7], 16'hBEEF);
    chk("stall_fwd_clear", {15'h0, out_fwd_valid}, 16'h0);
    read_a(4'd7, "stall_read", 16'hBEEF);

    // Writes to r0 are dropped and never forwarded.
    drive_wr(1'b1, 4'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0);
    tick();
    idle();
    in_rd_idx_b = 4'd0;
    #1;
    chk("r0_fwd_valid", {15'h0, out_fwd_valid}, 16'h0);
    chk("r0_bypass", out_rd_data_b, 16'h0);
    tick();
    read_a(4'd0, "r0_read", 16'h0);

    // Random write stream with random stalls.
    for (int c = 0; c < 60; c++) begin
      in_stall = ($urandom_range(0, 3) == 0);
      if (in_stall) begin
        in_act_write_res_to_reg = 1'b0;
      end else begin
        drive_wr(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom));
      end
      tick();
    end
    in_stall = 1'b0;
    idle();
    tick(); tick();
    for (int i = 0; i < 16; i++) read_a(4'(i), "rand_readback", model_rf[i]);

    // Reset while a write is pending (and stalled) drops the write.
    drive_wr(1'b1, 4'd9, 1'b0, 1'b0, 16'h5555, 16'h0);
    tick();
    idle();
    #1;
    chk("pre_rst_fwd_valid", {15'h0, out_fwd_valid}, 16'h1);
    reset = 1'b1;
    in_stall = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    in_stall = 1'b0;
    #1;
    chk("mid_rst_fwd_valid", {15'h0, out_fwd_valid}, 16'h0);
    chk("mid_rst_fwd_data", out_fwd_data, 16'h0);
    read_a(4'd9, "mid_rst_target", 16'h0);
    tick();
    for (int i = 0; i < 16; i++) read_a(4'(i), "mid_rst_all", 16'h0);

    chk("sb_empty", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
